// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: FSM state type, instruction-source
// select codes, the canned instruction words and the writeback IR selector.
package memory_stage_pkg;

    // Memory access FSM: IDLE accepts a new access, WAIT holds one in flight.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Instruction source select coming from the hazard/exception unit.
    localparam logic [1:0] IR_SRC_DATA   = 2'd0;
    localparam logic [1:0] IR_SRC_NOP    = 2'd1;
    localparam logic [1:0] IR_SRC_EXCEPT = 2'd2;

    // Canned instruction words injected into the pipeline.
    localparam logic [31:0] INST_NOP        = 32'h0000_0013;
    localparam logic [31:0] INST_BNE_EXCEPT = 32'hFC00_1EE3;

    // Instruction handed to writeback for a given source select. Unused
    // encodings degrade to a NOP so writeback never sees garbage.
    function automatic logic [31:0] ir_select(input logic [1:0]  src,
                                              input logic [31:0] ir_data);
        case (src)
            IR_SRC_DATA:   return ir_data;
            IR_SRC_EXCEPT: return INST_BNE_EXCEPT;
            default:       return INST_NOP;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_mem_wait_timer.sv
// Wait-cycle counter for an outstanding data-memory access. Counts cycles
// spent waiting for dmem_ack and flags the last permitted cycle. MAX_WAIT of
// zero disables the timeout flag entirely.
module mem_wait_timer #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic timeout_o
);

    // Counter only needs to reach MAX_WAIT-1.
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam int LAST  = (MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0;
    localparam logic [CNT_W-1:0] LAST_CNT = LAST[CNT_W-1:0];

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Timeout fires on the final allowed wait cycle.
    assign timeout_o = (MAX_WAIT != 0) && (cnt_q == LAST_CNT);

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage. Latches the instruction coming out of execute,
// performs the LD/LDR/ST data-memory access over a req/ack handshake, stalls
// upstream while the access is outstanding, aborts hung accesses with an
// exception and presents the result to writeback.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ir_src_mem,
    input  logic        op_ld_or_ldr,
    input  logic        op_st,
    input  logic        rf_w_mux_jump,
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic [31:0] y,
    input  logic [31:0] d,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] pc_next,
    output logic [31:0] ir_next,
    output logic [31:0] y_next,
    output logic [31:0] mdata_next,
    output logic        op_ld_or_ldr_next,
    output logic        rf_w_mux_jump_next,
    output logic        mem_err
);

    // Stage registers.
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] y_q;
    logic [31:0] d_q;
    logic        ld_q;
    logic        st_q;
    logic        jmp_q;

    mem_state_t  state_q;
    mem_state_t  state_d;

    logic        src_data;
    logic        in_wait;
    logic        req;
    logic        complete;
    logic        timeout;
    logic        tmr_timeout;

    // Handshake decode. Once in WAIT the request is committed and no longer
    // depends on ir_src_mem; addr/we/wdata stay stable because stall freezes
    // the stage registers that drive them.
    always_comb begin
        src_data = (ir_src_mem == IR_SRC_DATA);
        in_wait  = (state_q == WAIT);
        req      = in_wait | ((ld_q | st_q) & src_data);
        complete = req & dmem_ack;
        timeout  = in_wait & ~dmem_ack & tmr_timeout;
        stall    = req & ~dmem_ack & ~timeout;
    end

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (~in_wait),
        .en_i      (in_wait & ~dmem_ack),
        .timeout_o (tmr_timeout)
    );

    // FSM next state: enter WAIT on an unacknowledged issue, leave on ack or
    // timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req && !dmem_ack) state_d = WAIT;
            WAIT: if (complete || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register; a reset mid-access abandons the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Control part of the stage register: reset to a NOP with no side effects.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q  <= INST_NOP;
            ld_q  <= 1'b0;
            st_q  <= 1'b0;
            jmp_q <= 1'b0;
        end else if (!stall) begin
            ir_q  <= ir;
            ld_q  <= op_ld_or_ldr;
            st_q  <= op_st;
            jmp_q <= rf_w_mux_jump;
        end
    end

    // Datapath part of the stage register: no reset needed, control gates use.
    always_ff @(posedge clk) begin
        if (!stall) begin
            pc_q <= pc;
            y_q  <= y;
            d_q  <= d;
        end
    end

    // Memory port drive: word-aligned address, store data straight from d.
    always_comb begin
        dmem_req   = req;
        dmem_we    = req & st_q;
        dmem_addr  = {y_q[31:2], 2'b00};
        dmem_wdata = d_q;
        mem_err    = timeout;
    end

    // Writeback outputs: bubble while stalled, exception on timeout, otherwise
    // the latched instruction filtered by ir_src_mem.
    always_comb begin
        pc_next    = pc_q;
        y_next     = y_q;
        mdata_next = (complete & ld_q) ? dmem_rdata : 32'h0;
        if (stall) begin
            ir_next            = INST_NOP;
            op_ld_or_ldr_next  = 1'b0;
            rf_w_mux_jump_next = 1'b0;
        end else if (timeout) begin
            ir_next            = INST_BNE_EXCEPT;
            op_ld_or_ldr_next  = 1'b0;
            rf_w_mux_jump_next = 1'b0;
        end else begin
            ir_next            = ir_select(ir_src_mem, ir_q);
            op_ld_or_ldr_next  = ld_q & src_data;
            rf_w_mux_jump_next = jmp_q & src_data;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios followed by a random run, all
// checked against a transaction-level model of the stage.
module tb_memory_stage;
    import memory_stage_pkg::*;

    localparam int MAXW = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  ir_src_mem;
    logic        op_ld_or_ldr, op_st, rf_w_mux_jump;
    logic [31:0] pc, ir, y, d;
    logic        stall, dmem_req, dmem_we, dmem_ack, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] pc_next, ir_next, y_next, mdata_next;
    logic        op_ld_or_ldr_next, rf_w_mux_jump_next;

    memory_stage #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .ir_src_mem(ir_src_mem),
        .op_ld_or_ldr(op_ld_or_ldr), .op_st(op_st), .rf_w_mux_jump(rf_w_mux_jump),
        .pc(pc), .ir(ir), .y(y), .d(d),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc_next(pc_next), .ir_next(ir_next), .y_next(y_next), .mdata_next(mdata_next),
        .op_ld_or_ldr_next(op_ld_or_ldr_next), .rf_w_mux_jump_next(rf_w_mux_jump_next),
        .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: the instruction held in the stage, whether an access is in
    // flight and how many wait cycles it has used so far.
    typedef struct packed {
        logic [31:0] pc, ir, y, d;
        logic        ld, st, jmp;
    } instr_t;

    instr_t held;
    bit     busy   = 0;
    int     waited = 0;
    bit     known  = 0;

    // Outcome of the last driven cycle, applied to the model after its edge.
    bit     pend = 0;
    bit     p_rst, p_stall, p_busy;
    int     p_waited;
    instr_t p_in;

    function automatic logic [31:0] wb_ir(input logic [1:0] src, input logic [31:0] iw);
        if (src == IR_SRC_DATA)   return iw;
        if (src == IR_SRC_EXCEPT) return INST_BNE_EXCEPT;
        return INST_NOP;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // against the model, remember what the rising edge will do.
    task automatic step(input logic r, input logic [1:0] src,
                        input logic ld, input logic st, input logic jmp,
                        input logic [31:0] pcv, input logic [31:0] irv,
                        input logic [31:0] yv, input logic [31:0] dv,
                        input logic ack, input logic [31:0] rd);
        logic        e_req, e_stall, e_err, e_ld, e_jmp, sd;
        logic [31:0] e_ir, e_md;
        bit          nb;
        int          nw;
        @(negedge clk);
        if (pend) begin
            if (p_rst) begin
                held.ir = INST_NOP; held.ld = 0; held.st = 0; held.jmp = 0;
                busy = 0; waited = 0; known = 0;
            end else begin
                busy = p_busy; waited = p_waited;
                if (!p_stall) begin held = p_in; known = 1; end
            end
        end
        rst = r; ir_src_mem = src; op_ld_or_ldr = ld; op_st = st; rf_w_mux_jump = jmp;
        pc = pcv; ir = irv; y = yv; d = dv; dmem_ack = ack; dmem_rdata = rd;
        #1;
        sd    = (src == IR_SRC_DATA);
        e_req = busy || ((held.ld || held.st) && sd);
        e_err = 0; e_md = 32'h0; nb = busy; nw = waited;
        if (e_req && ack) begin
            e_stall = 0; e_md = held.ld ? rd : 32'h0;
            e_ir = wb_ir(src, held.ir); e_ld = held.ld && sd; e_jmp = held.jmp && sd;
            nb = 0;
        end else if (busy && waited == MAXW - 1) begin
            e_stall = 0; e_err = 1; e_ir = INST_BNE_EXCEPT; e_ld = 0; e_jmp = 0; nb = 0;
        end else if (e_req) begin
            e_stall = 1; e_ir = INST_NOP; e_ld = 0; e_jmp = 0;
            if (busy) nw = waited + 1; else begin nb = 1; nw = 0; end
        end else begin
            e_stall = 0; e_ir = wb_ir(src, held.ir); e_ld = held.ld && sd; e_jmp = held.jmp && sd;
        end
        if (!r) begin
            chk("stall", {31'b0, stall}, {31'b0, e_stall});
            chk("dmem_req", {31'b0, dmem_req}, {31'b0, e_req});
            chk("mem_err", {31'b0, mem_err}, {31'b0, e_err});
            chk("ir_next", ir_next, e_ir);
            chk("op_ld_next", {31'b0, op_ld_or_ldr_next}, {31'b0, e_ld});
            chk("jmp_next", {31'b0, rf_w_mux_jump_next}, {31'b0, e_jmp});
            chk("mdata_next", mdata_next, e_md);
            if (e_req) begin
                chk("dmem_we", {31'b0, dmem_we}, {31'b0, held.st});
                chk("dmem_addr", dmem_addr, {held.y[31:2], 2'b00});
                chk("dmem_wdata", dmem_wdata, held.d);
            end
            if (known) begin
                chk("pc_next", pc_next, held.pc);
                chk("y_next", y_next, held.y);
            end
        end
        pend = 1; p_rst = r; p_stall = e_stall; p_busy = nb; p_waited = nw;
        p_in = '{pc: pcv, ir: irv, y: yv, d: dv, ld: ld, st: st, jmp: jmp};
    endtask

    // Convenience: an ALU op with no memory side effects.
    task automatic idle(input logic [1:0] src, input logic ack, input logic [31:0] rd);
        step(0, src, 0, 0, 0, 32'h900, 32'h0000_0033, 32'h44, 32'h0, ack, rd);
    endtask

    initial begin
        rst = 1; ir_src_mem = IR_SRC_DATA; op_ld_or_ldr = 0; op_st = 0; rf_w_mux_jump = 0;
        pc = 0; ir = 0; y = 0; d = 0; dmem_ack = 0; dmem_rdata = 0;

        // Reset, then an ADD.
        step(1, IR_SRC_DATA, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, IR_SRC_DATA, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, IR_SRC_DATA, 0, 0, 0, 32'h100, 32'h0020_81B3, 32'h10, 32'h0, 0, 0);
        chk("rst_ir_next", ir_next, INST_NOP);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_req", {31'b0, dmem_req}, 32'h0);
        // LD y=0x107 enters while the ADD is presented.
        step(0, IR_SRC_DATA, 1, 0, 0, 32'h104, 32'h0000_A103, 32'h107, 32'h0, 0, 0);
        chk("add_ir", ir_next, 32'h0020_81B3);
        chk("add_y", y_next, 32'h10);
        // LD acked same cycle; ST y=0x200 d=0x55 enters.
        step(0, IR_SRC_DATA, 0, 1, 0, 32'h108, 32'h0050_2023, 32'h200, 32'h55, 1, 32'hDEAD_BEEF);
        chk("ld_addr", dmem_addr, 32'h104);
        chk("ld_mdata", mdata_next, 32'hDEAD_BEEF);
        chk("ld_flag", {31'b0, op_ld_or_ldr_next}, 32'h1);
        // ST waits three cycles, then acked.
        for (int i = 0; i < 3; i++) begin
            idle(IR_SRC_DATA, 0, 32'h0);
            chk("st_stall", {31'b0, stall}, 32'h1);
            chk("st_wdata", dmem_wdata, 32'h55);
        end
        idle(IR_SRC_DATA, 1, 32'h0);
        chk("st_retire_ir", ir_next, 32'h0050_2023);

        // LD with no ack: four stalled cycles then timeout.
        step(0, IR_SRC_DATA, 1, 0, 0, 32'h200, 32'h0001_2083, 32'h300, 32'h0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            idle(IR_SRC_DATA, 0, 32'h0);
            chk("to_stall", {31'b0, stall}, 32'h1);
        end
        idle(IR_SRC_DATA, 0, 32'h0);
        chk("to_err", {31'b0, mem_err}, 32'h1);
        chk("to_ir", ir_next, INST_BNE_EXCEPT);
        // ST annulled by ir_src_mem=NOP.
        step(0, IR_SRC_DATA, 0, 1, 0, 32'h300, 32'h0050_2223, 32'h240, 32'h77, 0, 0);
        chk("to_req_drop", {31'b0, dmem_req}, 32'h0);
        idle(IR_SRC_NOP, 0, 32'h0);
        chk("annul_req", {31'b0, dmem_req}, 32'h0);
        chk("annul_ir", ir_next, INST_NOP);

        // Reset during the second WAIT cycle, late ack, then a clean LD.
        step(0, IR_SRC_DATA, 1, 0, 0, 32'h400, 32'h0001_2183, 32'h400, 32'h0, 0, 0);
        idle(IR_SRC_DATA, 0, 32'h0);
        idle(IR_SRC_DATA, 0, 32'h0);
        step(1, IR_SRC_DATA, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, IR_SRC_DATA, 1, 0, 0, 32'h500, 32'h0001_2203, 32'h504, 32'h0, 1, 32'h1234_5678);
        chk("rstw_req", {31'b0, dmem_req}, 32'h0);
        chk("rstw_stall", {31'b0, stall}, 32'h0);
        chk("rstw_mdata", mdata_next, 32'h0);
        idle(IR_SRC_DATA, 1, 32'hCAFE_F00D);
        chk("after_rst_ld", mdata_next, 32'hCAFE_F00D);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            int kind, pct, srcr;
            logic [1:0] s;
            pct  = (c / 50) % 3 == 0 ? 70 : ((c / 50) % 3 == 1 ? 30 : 5);
            kind = $urandom_range(0, 3);
            srcr = $urandom_range(0, 9);
            s    = (srcr < 8) ? IR_SRC_DATA : ((srcr == 8) ? IR_SRC_NOP : IR_SRC_EXCEPT);
            step(($urandom_range(0, 99) < 2), s, kind == 1, kind == 2, kind == 3,
                 $urandom, $urandom, $urandom, $urandom,
                 ($urandom_range(0, 99) < pct), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
